// File: rtl/counter_uart_loader_pkg.sv
// Shared definitions for the serial loader: receiver FSM state codes and the
// load width of the downstream counter.
package counter_uart_loader_pkg;

    localparam int COUNTER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/counter_uart_loader_uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the half-bit and
// full-bit points relative to the last clear.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (clear || timer_q == FULL_LAST) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // The first cycle after a clear holds timer 0, so the tick lands on the
    // last count of each interval.
    assign half_tick = (timer_q == HALF_LAST);
    assign full_tick = (timer_q == FULL_LAST);

endmodule

// File: rtl/counter_uart_loader.sv
// 8N1 serial receiver producing a parallel load value and a one-cycle write
// strobe for the loadable counter; bad stop bits raise frame_err instead.
module counter_uart_loader
    import counter_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = COUNTER_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] wdata,
    output logic              wr,
    output logic              busy,
    output logic              frame_err
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [1:0]        sync_q;
    logic              rs_prev_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              frame_err_q, frame_err_d;

    logic rs;
    logic start_det;
    logic timer_clear;
    logic half_tick;
    logic full_tick;

    assign rs        = sync_q[1];
    assign start_det = (state_q == ST_IDLE) && !rs && rs_prev_q;
    // Re-zero the timer at the start-bit midpoint so full ticks fall mid-bit.
    assign timer_clear = (state_q == ST_IDLE) || ((state_q == ST_START) && half_tick);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sync_q      <= 2'b11;
            rs_prev_q   <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rxd};
            rs_prev_q   <= rs;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_det) state_d = ST_START;
            ST_START: if (half_tick) state_d = rs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (full_tick && bit_cnt_q == LAST_BIT) state_d = ST_STOP;
            ST_STOP:  if (full_tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_START: begin
                if (half_tick) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    shift_d   = {rs, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (full_tick) begin
                    if (rs) begin
                        wr_d    = 1'b1;
                        wdata_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign wdata     = wdata_q;
    assign wr        = wr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_counter_uart_loader.sv
// Scenario bench for counter_uart_loader: expected load values are queued as
// frames are sent and checked when the write strobe appears.
module tb_counter_uart_loader;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int WR_LAT = 2 + 2 + 9 * CPB + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          rxd   = 1'b1;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          busy;
    logic          frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int ferr_count  = 0;
    int last_wr_cyc = -1;
    int last_ferr_cyc = -1;
    logic prev_wr   = 1'b0;
    logic prev_ferr = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    counter_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .wdata    (wdata),
        .wr       (wr),
        .busy     (busy),
        .frame_err(frame_err)
    );

    // Scoreboard monitor: every strobe pops one expected byte.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_wr: got wdata=%h, required no strobe", wdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (wdata !== exp_v)
                    $display("FAIL wr_data: got %h, required %h", wdata, exp_v);
                else
                    n_pass++;
            end
            n_checks++;
            if (frame_err !== 1'b0 || prev_wr !== 1'b0)
                $display("FAIL wr_pulse: frame_err=%b prev_wr=%b, required 0 0", frame_err, prev_wr);
            else
                n_pass++;
            $display("wr    cycle=%0d wdata=%h", cyc, wdata);
        end
        if (frame_err === 1'b1) begin
            ferr_count++;
            last_ferr_cyc = cyc;
            n_checks++;
            if (prev_ferr !== 1'b0)
                $display("FAIL ferr_pulse: frame_err high for 2+ cycles, required 1");
            else
                n_pass++;
            $display("ferr  cycle=%0d wdata=%h", cyc, wdata);
        end
        prev_wr   = wr;
        prev_ferr = frame_err;
    end

    // Sends the first nbits bit periods of an 8N1 frame, starting at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rxd = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        #50;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (wdata !== 8'h00) $display("FAIL reset_wdata: got %h, required 00", wdata); else n_pass++;
        n_checks++; if (wr !== 1'b0) $display("FAIL reset_wr: got %b, required 0", wr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b, required 0", frame_err); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int w0, f0, fall;
        w0 = wr_count; f0 = ferr_count; fall = cyc;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 10);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (wr_count !== w0 + 1) $display("FAIL good_wr_count: got %0d, required %0d", wr_count - w0, 1); else n_pass++;
        n_checks++; if (ferr_count !== f0) $display("FAIL good_no_ferr: got %0d, required 0", ferr_count - f0); else n_pass++;
        n_checks++; if (last_wr_cyc !== fall + WR_LAT) $display("FAIL good_latency: got %0d, required %0d", last_wr_cyc - fall, WR_LAT); else n_pass++;
        n_checks++; if (wdata !== 8'h55) $display("FAIL good_hold: got %h, required 55", wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL good_idle: busy=%b, required 0", busy); else n_pass++;
    endtask

    task automatic test_bad_stop();
        int w0, f0, fall;
        w0 = wr_count; f0 = ferr_count; fall = cyc;
        send_frame(8'hA3, 1'b0, 10);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (ferr_count !== f0 + 1) $display("FAIL bad_ferr_count: got %0d, required 1", ferr_count - f0); else n_pass++;
        n_checks++; if (wr_count !== w0) $display("FAIL bad_no_wr: got %0d, required 0", wr_count - w0); else n_pass++;
        n_checks++; if (wdata !== 8'h55) $display("FAIL bad_wdata: got %h, required 55", wdata); else n_pass++;
        n_checks++; if (last_ferr_cyc !== fall + WR_LAT) $display("FAIL bad_latency: got %0d, required %0d", last_ferr_cyc - fall, WR_LAT); else n_pass++;
    endtask

    task automatic test_glitch();
        int w0, f0;
        w0 = wr_count; f0 = ferr_count;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL glitch_start: busy=%b, required 1", busy); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_reject: busy=%b, required 0", busy); else n_pass++;
        repeat (40) @(negedge clk);
        n_checks++; if (wr_count !== w0) $display("FAIL glitch_no_wr: got %0d, required 0", wr_count - w0); else n_pass++;
        n_checks++; if (ferr_count !== f0) $display("FAIL glitch_no_ferr: got %0d, required 0", ferr_count - f0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wr_count;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (wr_count !== w0 + 2) $display("FAIL b2b_wr_count: got %0d, required 2", wr_count - w0); else n_pass++;
        n_checks++; if (wdata !== 8'hFF) $display("FAIL b2b_last: got %h, required FF", wdata); else n_pass++;
    endtask

    task automatic test_break();
        int w0, f0;
        w0 = wr_count; f0 = ferr_count;
        rxd = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++; if (ferr_count !== f0 + 1) $display("FAIL break_ferr: got %0d, required 1", ferr_count - f0); else n_pass++;
        n_checks++; if (wr_count !== w0) $display("FAIL break_no_wr: got %0d, required 0", wr_count - w0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL break_no_restart: busy=%b, required 0", busy); else n_pass++;
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL break_release: busy=%b, required 0", busy); else n_pass++;
        n_checks++; if (ferr_count !== f0 + 1) $display("FAIL break_single: got %0d, required 1", ferr_count - f0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        w0 = wr_count;
        send_frame(8'h3C, 1'b1, 5);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (wdata !== 8'h00) $display("FAIL mid_wdata: got %h, required 00", wdata); else n_pass++;
        n_checks++; if (wr !== 1'b0) $display("FAIL mid_wr: got %b, required 0", wr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL mid_ferr: got %b, required 0", frame_err); else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (wr_count !== w0) $display("FAIL mid_no_wr: got %0d, required 0", wr_count - w0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_idle: busy=%b, required 0", busy); else n_pass++;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 10);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (wr_count !== w0 + 1) $display("FAIL mid_recover_count: got %0d, required 1", wr_count - w0); else n_pass++;
        n_checks++; if (wdata !== 8'h3C) $display("FAIL mid_recover_data: got %h, required 3C", wdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_glitch();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d expected bytes left, required 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
